// File: rtl/kbd_pkg.sv
// Shared constants for the PS/2 set-2 scan code decoder.
//   - prefix bytes (extended, break)
//   - modifier scan codes
//   - prefix FSM state encoding
//   - is_modifier(): true when {ext,code} names a shift, ctrl or caps key
package kbd_pkg;

    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BRK   = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } kbd_state_t;

    // Shift and caps exist only as plain codes; ctrl exists in both forms
    // (left = plain, right = E0-prefixed).
    function automatic logic is_modifier(input logic ext, input logic [7:0] code);
        return (!ext && (code == SC_LSHIFT || code == SC_RSHIFT || code == SC_CAPS))
               || (code == SC_CTRL);
    endfunction

endpackage

// File: rtl/scan2ascii.sv
// Combinational scan-code to ASCII lookup (set 2, US layout subset).
//   code  : make code without prefix
//   shift : shift modifier level
//   caps  : caps lock level
//   ascii : letters (case = shift ^ caps), digits / shifted symbols,
//           space, enter, backspace; 0x00 for anything else
module scan2ascii
    import kbd_pkg::*;
(
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);

    logic [7:0] letter;
    logic [7:0] digit;
    logic [7:0] sym;
    logic [7:0] misc;

    always_comb begin
        letter = 8'h00;
        digit  = 8'h00;
        sym    = 8'h00;
        misc   = 8'h00;
        case (code)
            8'h1C: letter = 8'h61; // a
            8'h32: letter = 8'h62;
            8'h21: letter = 8'h63;
            8'h23: letter = 8'h64;
            8'h24: letter = 8'h65;
            8'h2B: letter = 8'h66;
            8'h34: letter = 8'h67;
            8'h33: letter = 8'h68;
            8'h43: letter = 8'h69;
            8'h3B: letter = 8'h6A;
            8'h42: letter = 8'h6B;
            8'h4B: letter = 8'h6C;
            8'h3A: letter = 8'h6D;
            8'h31: letter = 8'h6E;
            8'h44: letter = 8'h6F;
            8'h4D: letter = 8'h70;
            8'h15: letter = 8'h71;
            8'h2D: letter = 8'h72;
            8'h1B: letter = 8'h73;
            8'h2C: letter = 8'h74;
            8'h3C: letter = 8'h75;
            8'h2A: letter = 8'h76;
            8'h1D: letter = 8'h77;
            8'h22: letter = 8'h78;
            8'h35: letter = 8'h79;
            8'h1A: letter = 8'h7A; // z
            8'h45: begin digit = 8'h30; sym = 8'h29; end // 0 )
            8'h16: begin digit = 8'h31; sym = 8'h21; end // 1 !
            8'h1E: begin digit = 8'h32; sym = 8'h40; end // 2 @
            8'h26: begin digit = 8'h33; sym = 8'h23; end // 3 #
            8'h25: begin digit = 8'h34; sym = 8'h24; end // 4 $
            8'h2E: begin digit = 8'h35; sym = 8'h25; end // 5 %
            8'h36: begin digit = 8'h36; sym = 8'h5E; end // 6 ^
            8'h3D: begin digit = 8'h37; sym = 8'h26; end // 7 &
            8'h3E: begin digit = 8'h38; sym = 8'h2A; end // 8 *
            8'h46: begin digit = 8'h39; sym = 8'h28; end // 9 (
            8'h29: misc = 8'h20;                         // space
            8'h5A: misc = 8'h0D;                         // enter
            8'h66: misc = 8'h08;                         // backspace
            default: ;
        endcase

        if (letter != 8'h00)
            ascii = (shift ^ caps) ? (letter - 8'h20) : letter;
        else if (digit != 8'h00)
            ascii = shift ? sym : digit;
        else
            ascii = misc;
    end

endmodule

// File: rtl/kbd_scancode_decoder.sv
// PS/2 set-2 scan code decoder.
//   clk, rst    : clock, synchronous active-high reset
//   scan_code   : received byte, qualified by wr (one-cycle strobe)
//   key_valid   : one-cycle pulse per non-modifier make (latency 1)
//   ascii       : ASCII of last non-modifier make (0x00 if extended/unmapped)
//   key_code    : last non-modifier make code, prefix stripped
//   is_ext      : key_code came with an E0 prefix
//   pressed     : a non-modifier key is currently held
//   shift, ctrl, caps_lock : modifier levels
//   press_cnt   : count of new key presses (wraps)
module kbd_scancode_decoder
    import kbd_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       scan_code,
    input  logic             wr,
    output logic             key_valid,
    output logic [7:0]       ascii,
    output logic [7:0]       key_code,
    output logic             is_ext,
    output logic             pressed,
    output logic             shift,
    output logic             ctrl,
    output logic             caps_lock,
    output logic [CNT_W-1:0] press_cnt
);

    kbd_state_t       state_reg;
    logic             key_valid_reg;
    logic [7:0]       ascii_reg;
    logic [7:0]       key_code_reg;
    logic             is_ext_reg;
    logic             pressed_reg;
    logic             lshift_reg;
    logic             rshift_reg;
    logic             lctrl_reg;
    logic             rctrl_reg;
    logic             caps_held_reg;
    logic             caps_lock_reg;
    logic [CNT_W-1:0] press_cnt_reg;

    logic             cur_ext;
    logic             cur_brk;
    logic [7:0]       ascii_next;

    assign cur_ext = (state_reg == S_EXT) || (state_reg == S_EXT_BRK);
    assign cur_brk = (state_reg == S_BRK) || (state_reg == S_EXT_BRK);

    // Lookup sees the modifier levels from before the current byte.
    scan2ascii u_scan2ascii (
        .code  (scan_code),
        .shift (lshift_reg | rshift_reg),
        .caps  (caps_lock_reg),
        .ascii (ascii_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            key_valid_reg <= 1'b0;
            ascii_reg     <= 8'h00;
            key_code_reg  <= 8'h00;
            is_ext_reg    <= 1'b0;
            pressed_reg   <= 1'b0;
            lshift_reg    <= 1'b0;
            rshift_reg    <= 1'b0;
            lctrl_reg     <= 1'b0;
            rctrl_reg     <= 1'b0;
            caps_held_reg <= 1'b0;
            caps_lock_reg <= 1'b0;
            press_cnt_reg <= '0;
        end else begin
            key_valid_reg <= 1'b0;
            if (wr) begin
                if (scan_code == PFX_EXT) begin
                    state_reg <= S_EXT;
                end else if (scan_code == PFX_BRK) begin
                    state_reg <= cur_ext ? S_EXT_BRK : S_BRK;
                end else begin
                    state_reg <= S_IDLE;
                    if (is_modifier(cur_ext, scan_code)) begin
                        if (scan_code == SC_LSHIFT) begin
                            lshift_reg <= !cur_brk;
                        end else if (scan_code == SC_RSHIFT) begin
                            rshift_reg <= !cur_brk;
                        end else if (scan_code == SC_CTRL) begin
                            if (cur_ext)
                                rctrl_reg <= !cur_brk;
                            else
                                lctrl_reg <= !cur_brk;
                        end else begin
                            // Caps: toggle only on the first make; typematic
                            // repeats are swallowed until the break arrives.
                            if (!cur_brk) begin
                                if (!caps_held_reg)
                                    caps_lock_reg <= ~caps_lock_reg;
                                caps_held_reg <= 1'b1;
                            end else begin
                                caps_held_reg <= 1'b0;
                            end
                        end
                    end else if (!cur_brk) begin
                        // {is_ext_reg,key_code_reg} doubles as the held key.
                        key_valid_reg <= 1'b1;
                        key_code_reg  <= scan_code;
                        is_ext_reg    <= cur_ext;
                        ascii_reg     <= cur_ext ? 8'h00 : ascii_next;
                        pressed_reg   <= 1'b1;
                        if (!pressed_reg || {is_ext_reg, key_code_reg} != {cur_ext, scan_code})
                            press_cnt_reg <= press_cnt_reg + 1'b1;
                    end else if (pressed_reg && {is_ext_reg, key_code_reg} == {cur_ext, scan_code}) begin
                        pressed_reg <= 1'b0;
                    end
                end
            end
        end
    end

    assign key_valid = key_valid_reg;
    assign ascii     = ascii_reg;
    assign key_code  = key_code_reg;
    assign is_ext    = is_ext_reg;
    assign pressed   = pressed_reg;
    assign shift     = lshift_reg | rshift_reg;
    assign ctrl      = lctrl_reg | rctrl_reg;
    assign caps_lock = caps_lock_reg;
    assign press_cnt = press_cnt_reg;

endmodule

// File: tb/tb_kbd_scancode_decoder.sv
module tb_kbd_scancode_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        wr = 1'b0;
    logic        key_valid;
    logic [7:0]  ascii;
    logic [7:0]  key_code;
    logic        is_ext;
    logic        pressed;
    logic        shift;
    logic        ctrl;
    logic        caps_lock;
    logic [15:0] press_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    kbd_scancode_decoder #(.CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_code (scan_code),
        .wr        (wr),
        .key_valid (key_valid),
        .ascii     (ascii),
        .key_code  (key_code),
        .is_ext    (is_ext),
        .pressed   (pressed),
        .shift     (shift),
        .ctrl      (ctrl),
        .caps_lock (caps_lock),
        .press_cnt (press_cnt)
    );

    typedef struct {
        logic [7:0]  code;
        logic        v;
        logic [7:0]  asc;
        logic [7:0]  kc;
        logic        e;
        logic        pr;
        logic        sh;
        logic        ct;
        logic        cp;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [7:0] code, input logic v, input logic [7:0] asc,
                                input logic [7:0] kc, input logic e, input logic pr,
                                input logic sh, input logic ct, input logic cp,
                                input logic [15:0] cnt);
        vec_t t;
        t.code = code; t.v = v; t.asc = asc; t.kc = kc; t.e = e;
        t.pr = pr; t.sh = sh; t.ct = ct; t.cp = cp; t.cnt = cnt;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input vec_t x);
        check({tag, " key_valid"}, int'(key_valid), int'(x.v));
        check({tag, " ascii"},     int'(ascii),     int'(x.asc));
        check({tag, " key_code"},  int'(key_code),  int'(x.kc));
        check({tag, " is_ext"},    int'(is_ext),    int'(x.e));
        check({tag, " pressed"},   int'(pressed),   int'(x.pr));
        check({tag, " shift"},     int'(shift),     int'(x.sh));
        check({tag, " ctrl"},      int'(ctrl),      int'(x.ct));
        check({tag, " caps_lock"}, int'(caps_lock), int'(x.cp));
        check({tag, " press_cnt"}, int'(press_cnt), int'(x.cnt));
    endtask

    // One wr cycle; outputs sampled on the following falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_code = b;
        wr = 1'b1;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    logic [7:0] letter_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                      8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                      8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] digit_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] digit_syms  [10] = '{8'h29,8'h21,8'h40,8'h23,8'h24,8'h25,8'h5E,8'h26,8'h2A,8'h28};

    function automatic logic [7:0] model_ascii(input logic [7:0] c, input logic sh, input logic cp);
        for (int i = 0; i < 26; i++)
            if (letter_codes[i] == c)
                return (sh != cp) ? 8'(8'h41 + i) : 8'(8'h61 + i);
        for (int i = 0; i < 10; i++)
            if (digit_codes[i] == c)
                return sh ? digit_syms[i] : 8'(8'h30 + i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        if (c == 8'h66) return 8'h08;
        return 8'h00;
    endfunction

    logic       m_ext_seen, m_brk_seen;
    logic       m_lsh, m_rsh, m_lct, m_rct, m_caps_down, m_caps;
    logic       m_pressed;
    logic [8:0] m_held;
    vec_t       m;

    function automatic void model_reset();
        m_ext_seen = 0; m_brk_seen = 0;
        m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0; m_caps_down = 0; m_caps = 0;
        m_pressed = 0; m_held = '0;
        m.v = 0; m.asc = 0; m.kc = 0; m.e = 0; m.pr = 0; m.sh = 0; m.ct = 0; m.cp = 0; m.cnt = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic e, brk;
        m.v = 0;
        if (b == 8'hE0) begin
            m_ext_seen = 1; m_brk_seen = 0;
        end else if (b == 8'hF0) begin
            m_brk_seen = 1;
        end else begin
            e = m_ext_seen; brk = m_brk_seen;
            m_ext_seen = 0; m_brk_seen = 0;
            if (!e && (b == 8'h12)) m_lsh = !brk;
            else if (!e && (b == 8'h59)) m_rsh = !brk;
            else if (b == 8'h14) begin if (e) m_rct = !brk; else m_lct = !brk; end
            else if (!e && (b == 8'h58)) begin
                if (brk) m_caps_down = 0;
                else begin if (!m_caps_down) m_caps = !m_caps; m_caps_down = 1; end
            end else if (!brk) begin
                m.v = 1;
                m.asc = e ? 8'h00 : model_ascii(b, m_lsh | m_rsh, m_caps);
                m.kc = b; m.e = e;
                if (!m_pressed || m_held != {e, b}) m.cnt = m.cnt + 16'd1;
                m_held = {e, b};
                m_pressed = 1;
            end else if (m_pressed && m_held == {e, b}) begin
                m_pressed = 0;
            end
        end
        m.pr = m_pressed; m.sh = m_lsh | m_rsh; m.ct = m_lct | m_rct; m.cp = m_caps;
    endfunction

    function automatic logic [7:0] rand_byte();
        int sel;
        sel = $urandom_range(0, 11);
        case (sel)
            0, 1:    return 8'hF0;
            2:       return 8'hE0;
            3: begin
                int k;
                k = $urandom_range(0, 3);
                return (k == 0) ? 8'h12 : (k == 1) ? 8'h59 : (k == 2) ? 8'h14 : 8'h58;
            end
            4, 5, 6: return letter_codes[$urandom_range(0, 25)];
            7:       return letter_codes[$urandom_range(0, 2)];
            8:       return digit_codes[$urandom_range(0, 9)];
            9: begin
                int k;
                k = $urandom_range(0, 2);
                return (k == 0) ? 8'h29 : (k == 1) ? 8'h5A : 8'h66;
            end
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        vec_t z;

        // ---------------- reset state ----------------
        do_reset();
        z.v = 0; z.asc = 0; z.kc = 0; z.e = 0; z.pr = 0; z.sh = 0; z.ct = 0; z.cp = 0; z.cnt = 0;
        z.code = 0;
        check_all("reset", z);
        $display("reset: state checked");

        // ---------------- table-driven directed sequences ----------------
        // make/break 'a'
        add(8'h1C,1,8'h61,8'h1C,0,1,0,0,0,16'd1);
        add(8'hF0,0,8'h61,8'h1C,0,1,0,0,0,16'd1);
        add(8'h1C,0,8'h61,8'h1C,0,0,0,0,0,16'd1);
        // shift + a
        add(8'h12,0,8'h61,8'h1C,0,0,1,0,0,16'd1);
        add(8'h1C,1,8'h41,8'h1C,0,1,1,0,0,16'd2);
        add(8'hF0,0,8'h41,8'h1C,0,1,1,0,0,16'd2);
        add(8'h1C,0,8'h41,8'h1C,0,0,1,0,0,16'd2);
        add(8'hF0,0,8'h41,8'h1C,0,0,1,0,0,16'd2);
        add(8'h12,0,8'h41,8'h1C,0,0,0,0,0,16'd2);
        // caps with typematic repeat
        add(8'h58,0,8'h41,8'h1C,0,0,0,0,1,16'd2);
        add(8'h58,0,8'h41,8'h1C,0,0,0,0,1,16'd2);
        add(8'hF0,0,8'h41,8'h1C,0,0,0,0,1,16'd2);
        add(8'h58,0,8'h41,8'h1C,0,0,0,0,1,16'd2);
        add(8'h1C,1,8'h41,8'h1C,0,1,0,0,1,16'd3);
        add(8'h12,0,8'h41,8'h1C,0,1,1,0,1,16'd3);
        add(8'h1C,1,8'h61,8'h1C,0,1,1,0,1,16'd3);
        add(8'hF0,0,8'h61,8'h1C,0,1,1,0,1,16'd3);
        add(8'h1C,0,8'h61,8'h1C,0,0,1,0,1,16'd3);
        // shifted digit, then plain digit
        add(8'h16,1,8'h21,8'h16,0,1,1,0,1,16'd4);
        add(8'hF0,0,8'h21,8'h16,0,1,1,0,1,16'd4);
        add(8'h16,0,8'h21,8'h16,0,0,1,0,1,16'd4);
        add(8'hF0,0,8'h21,8'h16,0,0,1,0,1,16'd4);
        add(8'h12,0,8'h21,8'h16,0,0,0,0,1,16'd4);
        add(8'h16,1,8'h31,8'h16,0,1,0,0,1,16'd5);
        add(8'hF0,0,8'h31,8'h16,0,1,0,0,1,16'd5);
        add(8'h16,0,8'h31,8'h16,0,0,0,0,1,16'd5);
        // left and right ctrl
        add(8'h14,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'hE0,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'h14,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'hF0,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'h14,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'hE0,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'hF0,0,8'h31,8'h16,0,0,0,1,1,16'd5);
        add(8'h14,0,8'h31,8'h16,0,0,0,0,1,16'd5);
        // extended key
        add(8'hE0,0,8'h31,8'h16,0,0,0,0,1,16'd5);
        add(8'h75,1,8'h00,8'h75,1,1,0,0,1,16'd6);
        add(8'hE0,0,8'h00,8'h75,1,1,0,0,1,16'd6);
        add(8'hF0,0,8'h00,8'h75,1,1,0,0,1,16'd6);
        add(8'h75,0,8'h00,8'h75,1,0,0,0,1,16'd6);
        // caps off again, then a, space
        add(8'h58,0,8'h00,8'h75,1,0,0,0,0,16'd6);
        add(8'hF0,0,8'h00,8'h75,1,0,0,0,0,16'd6);
        add(8'h58,0,8'h00,8'h75,1,0,0,0,0,16'd6);
        add(8'h1C,1,8'h61,8'h1C,0,1,0,0,0,16'd7);
        add(8'h29,1,8'h20,8'h29,0,1,0,0,0,16'd8);

        for (int i = 0; i < tbl.size(); i++) begin
            send_byte(tbl[i].code);
            check_all($sformatf("vec%0d", i), tbl[i]);
            $display("vec %0d: byte 0x%02h valid=%0d ascii=0x%02h cnt=%0d",
                     i, tbl[i].code, key_valid, ascii, press_cnt);
        end

        // key_valid must be a single-cycle pulse
        send_byte(8'h5A);
        check("enter valid", int'(key_valid), 1);
        check("enter ascii", int'(ascii), 8'h0D);
        @(negedge clk);
        check("pulse width", int'(key_valid), 0);
        $display("pulse: key_valid dropped after one cycle");

        // ---------------- repeat make does not count ----------------
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h1C);
            check($sformatf("rep%0d valid", i), int'(key_valid), 1);
            check($sformatf("rep%0d cnt", i), int'(press_cnt), 1);
            $display("repeat %0d: valid=%0d cnt=%0d", i, key_valid, press_cnt);
        end
        send_byte(8'h32);
        check("new key cnt", int'(press_cnt), 2);
        check("new key code", int'(key_code), 8'h32);
        check("new key held", int'(pressed), 1);
        send_byte(8'hF0);
        send_byte(8'h1C);
        check("stale break ignored", int'(pressed), 1);
        $display("new key: cnt=%0d pressed=%0d", press_cnt, pressed);

        // ---------------- reset mid-prefix, reset beats wr ----------------
        send_byte(8'hF0);
        @(negedge clk);
        rst = 1'b1; wr = 1'b1; scan_code = 8'h1C;
        @(negedge clk);
        rst = 1'b0; wr = 1'b0;
        check("rst prio valid", int'(key_valid), 0);
        check("rst prio cnt", int'(press_cnt), 0);
        send_byte(8'h1C);
        check("after rst valid", int'(key_valid), 1);
        check("after rst ascii", int'(ascii), 8'h61);
        check("after rst cnt", int'(press_cnt), 1);
        $display("reset mid-prefix: valid=%0d ascii=0x%02h", key_valid, ascii);

        // ---------------- press counter wrap ----------------
        do_reset();
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            scan_code = i[0] ? 8'h32 : 8'h1C;
            wr = 1'b1;
        end
        @(negedge clk);
        wr = 1'b0;
        check("cnt at max", int'(press_cnt), 16'hFFFF);
        $display("wrap: cnt=0x%04h before last press", press_cnt);
        send_byte(8'h32);
        check("cnt wrap", int'(press_cnt), 0);
        $display("wrap: cnt=0x%04h after last press", press_cnt);

        // ---------------- random against reference model ----------------
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] b;
            b = rand_byte();
            model_byte(b);
            send_byte(b);
            check_all($sformatf("rnd%0d", i), m);
            if (i % 300 == 0)
                $display("rnd %0d: byte 0x%02h valid=%0d ascii=0x%02h cnt=%0d",
                         i, b, key_valid, ascii, press_cnt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
